video_window_pad: RTL and testbench

- Single-clock successor to the crop/fill stage of the DVP video path.
- Crops a runtime-programmable window from an incoming vs/de pixel stream and buffers it in an internal FIFO.
- Emits a complete output frame of programmable size over a valid/ready interface, placing the window at a programmable offset and filling all other pixels with a border colour.
- Generalised in pixel width, channel count, coordinate width and buffer depth; feeds scaler or display stages.

---
 rtl/video_window_pad.sv | 184 ++++++++++++++++++
 tb/tb_video_window_pad.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_window_pad.sv
// Crops a vs/de window into a FIFO and emits a padded valid/ready frame around it.
// Define VWP_CHECKER_EN to draw the border as an 8x8 checkerboard for alignment debug.
module video_window_pad #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int X_W        = 12,
    parameter int Y_W        = 12,
    parameter int FIFO_DEPTH = 2048
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [X_W-1:0]                 start_x,
    input  logic [X_W-1:0]                 end_x,
    input  logic [Y_W-1:0]                 start_y,
    input  logic [Y_W-1:0]                 end_y,
    input  logic [X_W-1:0]                 out_h,
    input  logic [Y_W-1:0]                 out_v,
    input  logic [X_W-1:0]                 off_x,
    input  logic [Y_W-1:0]                 off_y,
    input  logic [DATA_WIDTH*CHANNELS-1:0] border_color,
    input  logic                           vi_vs,
    input  logic                           vi_de,
    input  logic [DATA_WIDTH*CHANNELS-1:0] vi_data,
    output logic                           vo_valid,
    input  logic                           vo_ready,
    output logic [DATA_WIDTH*CHANNELS-1:0] vo_data,
    output logic                           vo_sof,
    output logic                           vo_eol,
    output logic                           busy,
    output logic                           overflow,
    output logic                           cfg_err
);
    localparam int PW      = DATA_WIDTH * CHANNELS;
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             vs_d, de_d, vo_last;
    logic [X_W-1:0]   c_sx, c_ex, c_oh, c_offx, c_w, ix, ox;
    logic [Y_W-1:0]   c_sy, c_ey, c_ov, c_offy, c_h, iy, oy;
    logic [PW-1:0]    c_border, border_pix;
    logic [PW-1:0]    mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0] count;

    logic frame_start, de_fall, cfg_bad, in_win, o_is_win;
    logic fifo_full, fifo_empty, push_req, push, pop, load;
    logic [X_W-1:0] new_w;
    logic [Y_W-1:0] new_h;

    assign frame_start = vi_vs & ~vs_d;
    assign de_fall     = de_d & ~vi_de;
    assign busy        = (state == RUN);

    // Sums carry one extra bit so an oversized window cannot wrap into a valid-looking fit.
    assign new_w   = end_x - start_x;
    assign new_h   = end_y - start_y;
    assign cfg_bad = (end_x <= start_x) || (end_y <= start_y)
                  || (({1'b0, off_x} + {1'b0, new_w}) > ({1'b0, out_h} + (X_W+1)'(1)))
                  || (({1'b0, off_y} + {1'b0, new_h}) > ({1'b0, out_v} + (Y_W+1)'(1)));

    assign in_win   = (ix >= c_sx) && (ix < c_ex) && (iy >= c_sy) && (iy < c_ey);
    assign o_is_win = !cfg_err
                   && (ox >= c_offx) && ({1'b0, ox} < ({1'b0, c_offx} + {1'b0, c_w}))
                   && (oy >= c_offy) && ({1'b0, oy} < ({1'b0, c_offy} + {1'b0, c_h}));

`ifdef VWP_CHECKER_EN
    assign border_pix = (ox[3] ^ oy[3]) ? ~c_border : c_border;
`else
    assign border_pix = c_border;
`endif

    assign fifo_full  = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // A full FIFO still accepts a push in the cycle the output side pops it.
    assign load     = (state == RUN) && !frame_start
                   && (!vo_valid || (vo_ready && !vo_last))
                   && (!o_is_win || !fifo_empty);
    assign pop      = load && o_is_win;
    assign push_req = vi_de && in_win && (state != IDLE) && !cfg_err && !frame_start;
    assign push     = push_req && (!fifo_full || pop);

    // NOTE: the pixel store has no reset; occupancy is tracked by count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= vi_data;
    end

    // NOTE: every register here uses <= so all branches see pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vs_d     <= 1'b0;
            de_d     <= 1'b0;
            c_sx     <= '0;
            c_ex     <= '0;
            c_sy     <= '0;
            c_ey     <= '0;
            c_oh     <= '0;
            c_ov     <= '0;
            c_offx   <= '0;
            c_offy   <= '0;
            c_w      <= '0;
            c_h      <= '0;
            c_border <= '0;
            cfg_err  <= 1'b0;
            ix       <= '0;
            iy       <= '0;
            ox       <= '0;
            oy       <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            vo_valid <= 1'b0;
            vo_data  <= '0;
            vo_sof   <= 1'b0;
            vo_eol   <= 1'b0;
            vo_last  <= 1'b0;
        end else begin
            vs_d <= vi_vs;
            de_d <= vi_de;
            if (frame_start) begin
                c_sx     <= start_x;
                c_ex     <= end_x;
                c_sy     <= start_y;
                c_ey     <= end_y;
                c_oh     <= out_h;
                c_ov     <= out_v;
                c_offx   <= off_x;
                c_offy   <= off_y;
                c_w      <= new_w;
                c_h      <= new_h;
                c_border <= border_color;
                cfg_err  <= cfg_bad;
                ix       <= '0;
                iy       <= '0;
                ox       <= '0;
                oy       <= '0;
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
                overflow <= 1'b0;
                vo_valid <= 1'b0;
                vo_data  <= '0;
                vo_sof   <= 1'b0;
                vo_eol   <= 1'b0;
                vo_last  <= 1'b0;
                state    <= RUN;
            end else begin
                if (vi_de) begin
                    ix <= ix + X_W'(1);
                end else if (de_fall) begin
                    ix <= '0;
                    iy <= iy + Y_W'(1);
                end

                if (push) wptr <= wptr + FIFO_AW'(1);
                if (pop)  rptr <= rptr + FIFO_AW'(1);
                if (push && !pop)      count <= count + (FIFO_AW+1)'(1);
                else if (!push && pop) count <= count - (FIFO_AW+1)'(1);
                if (push_req && !push) overflow <= 1'b1;

                if (load) begin
                    vo_valid <= 1'b1;
                    vo_data  <= o_is_win ? mem[rptr] : border_pix;
                    vo_sof   <= (ox == '0) && (oy == '0);
                    vo_eol   <= (ox == c_oh);
                    vo_last  <= (ox == c_oh) && (oy == c_ov);
                    if (ox == c_oh) begin
                        ox <= '0;
                        oy <= oy + Y_W'(1);
                    end else begin
                        ox <= ox + X_W'(1);
                    end
                end else if (vo_valid && vo_ready) begin
                    vo_valid <= 1'b0;
                    if (vo_last) state <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_window_pad.sv
// Scoreboard bench for video_window_pad: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_video_window_pad;
    localparam int PW    = 24;
    localparam int XW    = 12;
    localparam int YW    = 12;
    localparam int DEPTH = 16;
    localparam int HB    = 24;
    localparam logic [PW-1:0] BORDER = 24'hABCDEF;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sof;
        logic          eol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [XW-1:0] start_x, end_x, out_h, off_x;
    logic [YW-1:0] start_y, end_y, out_v, off_y;
    logic [PW-1:0] border_color, vi_data, vo_data;
    logic vi_vs, vi_de, vo_valid, vo_ready, vo_sof, vo_eol, busy, overflow, cfg_err;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_count = 0;
    bit   rand_ready = 1'b0;

    video_window_pad #(
        .DATA_WIDTH(8), .CHANNELS(3), .X_W(XW), .Y_W(YW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_x(start_x), .end_x(end_x), .start_y(start_y), .end_y(end_y),
        .out_h(out_h), .out_v(out_v), .off_x(off_x), .off_y(off_y),
        .border_color(border_color),
        .vi_vs(vi_vs), .vi_de(vi_de), .vi_data(vi_data),
        .vo_valid(vo_valid), .vo_ready(vo_ready), .vo_data(vo_data),
        .vo_sof(vo_sof), .vo_eol(vo_eol),
        .busy(busy), .overflow(overflow), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int x, input int y, input int f);
        return {8'(8'h10 + y), 8'(8'h20 + x), 8'(f)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) vo_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic set_cfg(input int sx, input int ex, input int sy, input int ey,
                           input int oh, input int ov, input int ofx, input int ofy);
        start_x = XW'(sx); end_x = XW'(ex); start_y = YW'(sy); end_y = YW'(ey);
        out_h = XW'(oh); out_v = YW'(ov); off_x = XW'(ofx); off_y = YW'(ofy);
    endtask

    // Expected output frame in raster order; stops where the output would stall for want of window data.
    task automatic push_exp(input int sx, input int sy, input int ofx, input int ofy,
                            input int w, input int h, input int oh, input int ov,
                            input int f, input int max_win);
        int nw;
        nw = 0;
        for (int y = 0; y <= ov; y++) begin
            for (int x = 0; x <= oh; x++) begin
                bit   win;
                exp_t e;
                win = (x >= ofx) && (x < ofx + w) && (y >= ofy) && (y < ofy + h);
                if (win && nw >= max_win) return;
                e.data = win ? pix(sx + x - ofx, sy + y - ofy, f) : BORDER;
                e.sof  = (x == 0) && (y == 0);
                e.eol  = (x == oh);
                if (win) nw++;
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input bit exp_err);
        vi_vs = 1'b1;
        tick();
        check("start_valid_clr", 32'(vo_valid), 32'd0);
        check("start_ovf_clr", 32'(overflow), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_cfg_err", 32'(cfg_err), 32'(exp_err));
        vi_vs = 1'b0;
        tick();
    endtask

    // 16x8 input frame with HB blanking cycles after every line.
    task automatic drive_frame(input int f, input bit chk_ovf);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                vi_de   = 1'b1;
                vi_data = pix(x, y, f);
                tick();
                if (chk_ovf && y == 1 && x == 7) check("ovf_after_16", 32'(overflow), 32'd0);
                if (chk_ovf && y == 2 && x == 0) check("ovf_after_17", 32'(overflow), 32'd1);
            end
            vi_de   = 1'b0;
            vi_data = '0;
            repeat (HB) tick();
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin : monitor
        exp_t held;
        exp_t e;
        bit   hold_pend;
        logic [PW+1:0] now;
        hold_pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                now = {vo_data, vo_sof, vo_eol};
                if (hold_pend && rand_ready) begin
                    check("hold_valid", 32'(vo_valid), 32'd1);
                    check("hold_data", 32'(now), 32'(held));
                end
                if (vo_valid && vo_ready) begin
                    acc_count++;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out: got %0h expected no pixel", vo_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 32'(vo_data), 32'(e.data));
                        check("out_sof", 32'(vo_sof), 32'(e.sof));
                        check("out_eol", 32'(vo_eol), 32'(e.eol));
                    end
                end
                hold_pend = vo_valid && !vo_ready;
                held = now;
            end
        end
    end

    initial begin : stim
        int base;
        int n;
        vi_vs = 1'b0; vi_de = 1'b0; vi_data = '0; vo_ready = 1'b0;
        border_color = BORDER;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(vo_valid), 32'd0);
        check("rst_data", 32'(vo_data), 32'd0);
        check("rst_sof", 32'(vo_sof), 32'd0);
        check("rst_eol", 32'(vo_eol), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Centered crop, free-running sink.
        set_cfg(4, 12, 2, 6, 15, 7, 4, 2);
        vo_ready = 1'b1;
        push_exp(4, 2, 4, 2, 8, 4, 15, 7, 1, 1000);
        start_frame(1'b0);
        drive_frame(1, 1'b0);
        wait_drain("crop", 2000);
        tick();
        check("crop_busy_done", 32'(busy), 32'd0);
        check("crop_ovf", 32'(overflow), 32'd0);

        // Same frame under random backpressure.
        rand_ready = 1'b1;
        push_exp(4, 2, 4, 2, 8, 4, 15, 7, 2, 1000);
        start_frame(1'b0);
        drive_frame(2, 1'b0);
        wait_drain("bp", 3000);
        rand_ready = 1'b0;
        vo_ready = 1'b1;
        tick();
        check("bp_busy_done", 32'(busy), 32'd0);
        check("bp_ovf", 32'(overflow), 32'd0);

        // Window does not fit: off_x 10 + W 8 > 16.
        set_cfg(0, 8, 0, 4, 15, 7, 10, 2);
        push_exp(0, 0, 10, 2, 0, 0, 15, 7, 3, 1000);
        start_frame(1'b1);
        drive_frame(3, 1'b0);
        wait_drain("cfg", 500);
        check("cfg_no_push", 32'(overflow), 32'd0);
        check("cfg_err_held", 32'(cfg_err), 32'd1);
        check("cfg_busy_done", 32'(busy), 32'd0);

        // 32-pixel window into a 16-entry FIFO with the sink blocked.
        set_cfg(0, 8, 0, 4, 15, 7, 4, 2);
        vo_ready = 1'b0;
        push_exp(0, 0, 4, 2, 8, 4, 15, 7, 4, 16);
        start_frame(1'b0);
        drive_frame(4, 1'b1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        vo_ready = 1'b1;
        wait_drain("ovf", 500);
        repeat (20) tick();
        check("ovf_stalled_valid", 32'(vo_valid), 32'd0);
        check("ovf_stalled_busy", 32'(busy), 32'd1);

        // Mid-frame restart after 40 accepted pixels.
        set_cfg(4, 12, 2, 4, 15, 7, 4, 2);
        vo_ready = 1'b0;
        push_exp(4, 2, 4, 2, 8, 2, 15, 7, 5, 1000);
        start_frame(1'b0);
        drive_frame(5, 1'b0);
        check("exact_full_no_ovf", 32'(overflow), 32'd0);
        base = acc_count;
        vo_ready = 1'b1;
        n = 0;
        while (acc_count - base < 40 && n < 200) begin
            tick();
            n++;
        end
        vo_ready = 1'b0;
        check("restart_accepted", 32'(acc_count - base), 32'd40);
        tick();
        sb.delete();
        set_cfg(4, 12, 2, 6, 15, 7, 4, 2);
        push_exp(4, 2, 4, 2, 8, 4, 15, 7, 6, 1000);
        start_frame(1'b0);
        vo_ready = 1'b1;
        drive_frame(6, 1'b0);
        wait_drain("restart", 2000);
        check("restart_ovf", 32'(overflow), 32'd0);

        // Asynchronous reset while a held pixel is pending.
        set_cfg(0, 8, 0, 4, 15, 7, 10, 2);
        vo_ready = 1'b0;
        start_frame(1'b1);
        repeat (3) tick();
        check("pre_rst_valid", 32'(vo_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(vo_valid), 32'd0);
        check("arst_data", 32'(vo_data), 32'd0);
        check("arst_sof", 32'(vo_sof), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cfg_err", 32'(cfg_err), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        vo_ready = 1'b1;
        repeat (20) tick();
        check("post_rst_idle_valid", 32'(vo_valid), 32'd0);
        check("post_rst_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
